// File: rtl/unidir_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unidir_bus_arbiter_if: request/grant bundle between masters, arbiter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface unidir_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] lock;
  logic       done;
  logic [1:0] ack;
  logic       busy;
  logic       timeout_err;

  modport master (output req, lock, done, input ack, busy, timeout_err);
  modport slave  (input req, lock, done, output ack, busy, timeout_err);
endinterface
`default_nettype wire

// File: rtl/unidir_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unidir_bus_arbiter: 2-master grant sequencer, turnaround/timeout/starve|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module unidir_bus_arbiter #(
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  unidir_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_TCNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] C_STARVE    = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] C_ONE       = CNT_WIDTH'(1);

  state_t               r_state;
  logic [1:0]           r_ack;
  logic                 r_timeout_err;
  logic [CNT_WIDTH-1:0] r_tcnt;
  logic [CNT_WIDTH-1:0] r_wcnt;

  logic w_starve;
  logic w_own;
  logic w_own_req;
  logic w_own_lock;

  assign w_starve   = (r_wcnt == C_STARVE);
  assign w_own      = (r_state == GNT2);
  assign w_own_req  = bus.req[w_own];
  assign w_own_lock = bus.lock[w_own];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ack         <= 2'b00;
      r_timeout_err <= 1'b0;
      r_tcnt        <= '0;
      r_wcnt        <= '0;
    end else begin
      r_timeout_err <= 1'b0;

      // Master 2 waiting time, measured against the currently driven grant
      if (!bus.req[1] || r_ack == 2'b10) begin
        r_wcnt <= '0;
      end else if (!w_starve) begin
        r_wcnt <= r_wcnt + C_ONE;
      end

      case (r_state)
        IDLE, TURN: begin
          r_tcnt <= '0;
          if (w_starve && bus.req[1]) begin
            r_state <= GNT2;
            r_ack   <= 2'b10;
          end else if (bus.req[0]) begin
            r_state <= GNT1;
            r_ack   <= 2'b01;
          end else if (bus.req[1]) begin
            r_state <= GNT2;
            r_ack   <= 2'b10;
          end else begin
            r_state <= IDLE;
            r_ack   <= 2'b00;
          end
        end

        GNT1, GNT2: begin
          if (!w_own_req) begin
            r_state <= TURN;
            r_ack   <= 2'b00;
          end else if (bus.done) begin
            // A starving Master 2 breaks Master 1's lock at the transaction boundary
            if (w_own_lock && !(r_state == GNT1 && w_starve)) begin
              r_tcnt <= '0;
            end else begin
              r_state <= TURN;
              r_ack   <= 2'b00;
            end
          end else if (r_tcnt == C_TCNT_LAST) begin
            r_state       <= TURN;
            r_ack         <= 2'b00;
            r_timeout_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + C_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_ack   <= 2'b00;
        end
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.busy        = |r_ack;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_unidir_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unidir_bus_arbiter: directed self-checking bench for the arbiter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_unidir_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] prev_ack;

  unidir_bus_arbiter_if bus ();

  unidir_bus_arbiter #(
    .TIMEOUT      (64),
    .STARVE_LIMIT (8),
    .CNT_WIDTH    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge
  task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic d,
                     input logic [1:0] exp_ack, input logic exp_terr, input string tag);
    bus.req  = r;
    bus.lock = l;
    bus.done = d;
    @(posedge clk);
    #1;
    check({tag, ".ack"},  32'(bus.ack),         32'(exp_ack));
    check({tag, ".busy"}, 32'(bus.busy),        32'(exp_ack != 2'b00));
    check({tag, ".terr"}, 32'(bus.timeout_err), 32'(exp_terr));
    check({tag, ".nodirect"}, 32'((prev_ack ^ bus.ack) == 2'b11), 32'(0));
    prev_ack = bus.ack;
  endtask

  logic [1:0] s2_ack [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s2_ack = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01,
               2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.lock = 2'b00;
    bus.done = 1'b0;
    prev_ack = 2'b00;

    @(posedge clk);
    #1;
    check("rst.ack",  32'(bus.ack),         32'(0));
    check("rst.busy", 32'(bus.busy),        32'(0));
    check("rst.terr", 32'(bus.timeout_err), 32'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Basic grant and release
    cyc(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, "s1_grant");
    cyc(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, "s1_hold0");
    cyc(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, "s1_hold1");
    cyc(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, "s1_done");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s1_idle");
    cyc(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, "s1_done_ignored");

    // Both masters requesting, done in every 3rd grant cycle
    for (int k = 0; k < 13; k++) begin
      cyc(2'b11, 2'b00, ((k % 4) == 3), s2_ack[k], 1'b0, "s2_alt");
    end
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s2_abort");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s2_idle");

    // Locked back-to-back transactions for Master 1
    cyc(2'b01, 2'b01, 1'b0, 2'b01, 1'b0, "s3_grant");
    cyc(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "s3_lock_done1");
    cyc(2'b01, 2'b01, 1'b0, 2'b01, 1'b0, "s3_lock_hold");
    cyc(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "s3_lock_done2");
    cyc(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, "s3_lock_done3");
    cyc(2'b11, 2'b01, 1'b0, 2'b01, 1'b0, "s3_m2_req");
    cyc(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, "s3_unlock_done");
    cyc(2'b10, 2'b00, 1'b0, 2'b10, 1'b0, "s3_m2_grant");
    cyc(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, "s3_m2_done");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s3_idle");

    // Master 2 holds the bus without done until the timeout revokes it
    cyc(2'b10, 2'b00, 1'b0, 2'b10, 1'b0, "s4_grant");
    for (int i = 1; i < 64; i++) begin
      cyc(2'b11, 2'b00, 1'b0, 2'b10, 1'b0, "s4_hold");
    end
    cyc(2'b11, 2'b00, 1'b0, 2'b00, 1'b1, "s4_revoke");
    cyc(2'b11, 2'b00, 1'b0, 2'b01, 1'b0, "s4_m1_after");

    // Request drop coinciding with done releases exactly once
    cyc(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, "s5_drop_done");
    cyc(2'b10, 2'b00, 1'b0, 2'b10, 1'b0, "s5_m2_grant");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s5_m2_drop");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s5_idle");

    // Asynchronous reset in the middle of a Master 2 grant
    cyc(2'b10, 2'b00, 1'b0, 2'b10, 1'b0, "s6_gnt2");
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_async.ack",  32'(bus.ack),  32'(0));
    check("s6_async.busy", 32'(bus.busy), 32'(0));
    bus.req = 2'b01;
    @(posedge clk);
    #1;
    check("s6_held.ack", 32'(bus.ack), 32'(0));
    #3;
    rst_n    = 1'b1;
    prev_ack = 2'b00;
    cyc(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, "s6_post");

    // Wait counter starts from zero: lock survives 8 dones, then starvation wins
    for (int i = 0; i < 8; i++) begin
      cyc(2'b11, 2'b01, 1'b1, 2'b01, 1'b0, "s6_lock_wait");
    end
    cyc(2'b11, 2'b01, 1'b1, 2'b00, 1'b0, "s6_starve_break");
    cyc(2'b11, 2'b01, 1'b1, 2'b10, 1'b0, "s6_starve_m2");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s6_m2_drop");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, "s6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unidir_bus_arbiter.md
# unidir_bus_arbiter

Two-master arbiter for the unidirectional bus (2 masters, 4 slaves). It produces the registered 2-bit acknowledge that drives the select input of the master-to-bus multiplexer: 01 = Master 1 (high priority), 10 = Master 2 (low priority), 00 = bus released. It owns grant sequencing, a one-cycle turnaround between owners, transaction timeout and starvation protection for Master 2.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles a grant may stay open without `done`; must be < 2^CNT_WIDTH.
- STARVE_LIMIT, 8: cycles Master 2 may wait while requesting before it is forced ahead of Master 1; must be < 2^CNT_WIDTH.
- CNT_WIDTH, 8: width of the internal timeout and wait counters.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req, input, 2: bus requests; req[0] = Master 1, req[1] = Master 2; level-held.
- lock, input, 2: per-master request to keep ownership across back-to-back transactions.
- done, input, 1: one-cycle pulse from the addressed slave marking the end of the current transaction.
- ack, output, 2: registered grant and mux select; only 00, 01 or 10.
- busy, output, 1: high whenever ack != 00.
- timeout_err, output, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE (ack=00), GNT1 (ack=01), GNT2 (ack=10), TURN (ack=00, exactly one cycle).
- Arbitration in IDLE and TURN:
  - If starve is set and req[1]=1, go to GNT2.
  - Otherwise, if req[0]=1, go to GNT1.
  - Otherwise, if req[1]=1, go to GNT2.
  - Otherwise, go to IDLE.
- In GNTx, where x is the owner:
  - If req[x]=0, the request was aborted; go to TURN. This takes precedence over `done` in the same cycle.
  - If done=1, lock[x]=1, req[x]=1, and not (x=1 and starve), stay in GNTx and clear the timeout counter.
  - If done=1 otherwise, go to TURN.
  - If the timeout counter equals TIMEOUT-1 with done=0, go to TURN and pulse timeout_err in the next cycle.
  - Otherwise, hold and increment the timeout counter.
- Timeout counter:
  - Cleared on entry to any GNT state and on every retained `done`.
  - Increments each cycle in GNTx; never wraps (the revoke happens first).
- Wait counter:
  - Increments while req[1]=1 and ack!=10, saturating at STARVE_LIMIT.
  - Cleared when ack=10 or req[1]=0.
  - starve = (wait counter == STARVE_LIMIT).
- `done` is ignored in IDLE and TURN. `lock` is sampled only together with `done`.
- A direct transition GNT1 <-> GNT2 is not allowed; every ownership change passes through TURN, so tristate drivers never overlap.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, ack=00, busy=0, timeout_err=0, both counters 0.
- Grant latency: a req sampled at edge n in IDLE or TURN gives a valid ack after edge n (one cycle).
- Release latency: done or a req drop at edge n gives ack=00 after edge n. The next grant is valid after edge n+1, so the minimum gap between owners is 1 cycle.
- Locked back-to-back transactions keep ack constant with zero dead cycles.
- timeout_err is high for exactly the one cycle in which ack first reads 00 after the revoke.
- busy is derived combinationally from the registered ack and adds no extra latency.
- Reset asserted mid-grant forces ack=00 immediately, without waiting for a clock edge.

## Test plan
- Reset, then req=01 at cycle 2: ack=01 from cycle 3. done at cycle 6 gives ack=00 at cycle 7 (TURN), then IDLE; busy tracks ack throughout.
- req=11 held, lock=00, done every 3rd cycle of a grant: grants alternate 01, 00, 10 (after STARVE_LIMIT=8 waits), 00, 01. ack is never 11, and there is never a direct 01->10 transition.
- M1 with lock[0]=1 and req[0] held, done pulsed 3 times: ack stays 01 with no gaps. Dropping lock[0] at the 4th done gives TURN, then a grant to M2 if req[1]=1.
- TIMEOUT=64, grant M2 with no done: revoke after 64 grant cycles; timeout_err=1 for one cycle with ack=00; a pending M1 is granted on the following cycle.
- M1 drops req[0] mid-grant in the same cycle as done: exactly one release, TURN for one cycle, no timeout_err.
- rst_n pulled low during GNT2 between clock edges: ack=00 immediately. After release with req=01, ack=01 one cycle later, and the wait counter restarts from 0.
